// File: rtl/uart_receiver_multi.sv
// rtl/uart_receiver_multi.sv - oversampling UART receiver with 3-sample vote, parity, framing and break detection
`timescale 1ns/1ps
module uart_receiver_multi #(
  parameter int MAX_BITS = 9,
  parameter int OSR      = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RXCLK,
  input  logic                RXCLEAR,
  input  logic [3:0]          WLEN,
  input  logic                PEN,
  input  logic                EPS,
  input  logic                SP,
  input  logic                STB,
  input  logic                SIN,
  output logic [MAX_BITS-1:0] DOUT,
  output logic                PE,
  output logic                FE,
  output logic                BI,
  output logic                RXFINISHED,
  output logic                BUSY
);
  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] T_S0   = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OSR/2);
  localparam logic [TW-1:0] T_VOTE = TW'(OSR/2 + 1);
  localparam logic [TW-1:0] T_WRAP = TW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2, S_BRKWAIT
  } state_t;

  state_t state, state_next;
  logic sin_meta, sin_sync;
  logic [TW-1:0] tick_cnt;
  logic [3:0] bit_cnt, wlen_c, wlen_q;
  logic pen_q, eps_q, sp_q, stb_q;
  logic samp_a, samp_b, rp, stop1;
  logic [MAX_BITS-1:0] shreg;
  logic vote_tick, wrap_tick, vote, first_stop, par_exp;
  logic pe_c, fe_c, bi_c, done, start_enter, counting;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sin_meta <= 1'b1;
      sin_sync <= 1'b1;
    end else begin
      sin_meta <= SIN;
      sin_sync <= sin_meta;
    end
  end

  always_comb begin
    wlen_c = WLEN;
    if (WLEN < 4'd5) wlen_c = 4'd5;
    else if (WLEN > 4'(MAX_BITS)) wlen_c = 4'(MAX_BITS);
  end

  assign vote_tick  = RXCLK && (tick_cnt == T_VOTE);
  assign wrap_tick  = RXCLK && (tick_cnt == T_WRAP);
  assign vote       = (samp_a & samp_b) | (samp_a & sin_sync) | (samp_b & sin_sync);
  // With two stop bits the first one was voted a bit earlier and stored.
  assign first_stop = (state == S_STOP2) ? stop1 : vote;
  assign par_exp    = sp_q ? ~eps_q : ((^shreg) ^ ~eps_q);
  assign pe_c       = pen_q & (rp != par_exp);
  assign fe_c       = ~first_stop | ~vote;
  assign bi_c       = (shreg == '0) & (~pen_q | ~rp) & ~first_stop;
  assign counting   = (state != S_IDLE) && (state != S_BRKWAIT);
  assign start_enter = (state == S_IDLE) && (state_next == S_START);
  assign BUSY       = (state != S_IDLE);

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      S_IDLE:    if (RXCLK && !sin_sync) state_next = S_START;
      S_START: begin
        if (vote_tick && vote) state_next = S_IDLE;
        else if (wrap_tick)    state_next = S_DATA;
      end
      S_DATA:    if (wrap_tick && (bit_cnt == wlen_q - 4'd1)) state_next = pen_q ? S_PAR : S_STOP1;
      S_PAR:     if (wrap_tick) state_next = S_STOP1;
      S_STOP1: begin
        if (vote_tick && !stb_q)     done = 1'b1;
        else if (wrap_tick && stb_q) state_next = S_STOP2;
      end
      S_STOP2:   if (vote_tick) done = 1'b1;
      S_BRKWAIT: if (RXCLK && sin_sync) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (done) state_next = (bi_c || !vote) ? S_BRKWAIT : S_IDLE;
    if (RXCLEAR) begin
      state_next = S_IDLE;
      done       = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      rp         <= 1'b0;
      stop1      <= 1'b0;
      wlen_q     <= 4'd5;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      stb_q      <= 1'b0;
      DOUT       <= '0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      RXFINISHED <= done;
      if (done) begin
        DOUT <= shreg;
        PE   <= pe_c;
        FE   <= fe_c;
        BI   <= bi_c;
      end
      if (RXCLEAR) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (start_enter) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
        wlen_q   <= wlen_c;
        pen_q    <= PEN;
        eps_q    <= EPS;
        sp_q     <= SP;
        stb_q    <= STB;
      end else if (RXCLK && counting) begin
        tick_cnt <= (tick_cnt == T_WRAP) ? '0 : tick_cnt + TW'(1);
        if (tick_cnt == T_S0) samp_a <= sin_sync;
        if (tick_cnt == T_S1) samp_b <= sin_sync;
        if (vote_tick) begin
          case (state)
            S_DATA:  shreg <= shreg | (MAX_BITS'(vote) << bit_cnt);
            S_PAR:   rp    <= vote;
            S_STOP1: stop1 <= vote;
            default: ;
          endcase
        end
        if (wrap_tick && state == S_DATA) bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver_multi.sv
// tb/tb_uart_receiver_multi.sv - randomized scoreboard bench for uart_receiver_multi
`timescale 1ns/1ps
module tb_uart_receiver_multi;
  logic       CLK = 1'b0, RST = 1'b1, RXCLK = 1'b0, RXCLEAR = 1'b0;
  logic [3:0] WLEN = 4'd8;
  logic       PEN = 1'b0, EPS = 1'b0, SP = 1'b0, STB = 1'b0, SIN = 1'b1;
  logic [8:0] DOUT;
  logic       PE, FE, BI, RXFINISHED, BUSY;

  uart_receiver_multi #(.MAX_BITS(9), .OSR(16)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR), .WLEN(WLEN),
    .PEN(PEN), .EPS(EPS), .SP(SP), .STB(STB), .SIN(SIN),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .RXFINISHED(RXFINISHED), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [8:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0, n_pass = 0;
  int         tick_per = 4, tick_count = 0;
  int         start_tick = 0, finish_tick = 0;
  logic [8:0] last_dout = '0;
  logic [8:0] rword;
  logic       p, rpen, reps, rsp, rstb, rs1, rs2;
  int         rwlen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int clamp_w(input int wlen_raw);
    return (wlen_raw < 5) ? 5 : ((wlen_raw > 9) ? 9 : wlen_raw);
  endfunction

  function automatic logic [8:0] data_of(input logic [8:0] word, input int wlen_raw);
    logic [8:0] mask;
    mask = 9'((1 << clamp_w(wlen_raw)) - 1);
    return word & mask;
  endfunction

  function automatic logic good_par(input logic [8:0] word, input int wlen_raw, input logic eps, input logic sp);
    if (sp) return !eps;
    return ($countones(data_of(word, wlen_raw)) % 2 == 1) ^ !eps;
  endfunction

  function automatic exp_t model(input logic [8:0] word, input int wlen_raw, input logic pen, input logic eps,
                                 input logic sp, input logic stb, input logic pbit, input logic s1, input logic s2);
    exp_t e;
    e.dout = data_of(word, wlen_raw);
    e.pe   = pen && (pbit != good_par(word, wlen_raw, eps, sp));
    e.fe   = !s1 || (stb && !s2);
    e.bi   = (e.dout == 0) && (!pen || !pbit) && !s1;
    return e;
  endfunction

  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge CLK);
      if (tdiv >= tick_per - 1) begin
        RXCLK = 1'b1;
        tdiv  = 0;
        tick_count++;
      end else begin
        RXCLK = 1'b0;
        tdiv++;
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      while (!RXCLK) @(posedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic send_frame(input logic [8:0] word, input int wlen_raw, input logic pen, input logic eps,
                            input logic sp, input logic stb, input logic pbit, input logic s1, input logic s2,
                            input bit scramble, input int gap);
    exp_t e;
    WLEN = 4'(wlen_raw); PEN = pen; EPS = eps; SP = sp; STB = stb;
    e = model(word, wlen_raw, pen, eps, sp, stb, pbit, s1, s2);
    exp_q.push_back(e);
    last_dout  = e.dout;
    start_tick = tick_count;
    SIN = 1'b0;
    wait_ticks(8);
    if (scramble) begin
      WLEN = 4'($urandom); PEN = 1'($urandom); EPS = 1'($urandom); SP = 1'($urandom); STB = 1'($urandom);
    end
    wait_ticks(8);
    for (int i = 0; i < clamp_w(wlen_raw); i++) begin
      SIN = word[i];
      wait_ticks(16);
    end
    if (pen) begin SIN = pbit; wait_ticks(16); end
    SIN = s1; wait_ticks(16);
    if (stb) begin SIN = s2; wait_ticks(16); end
    SIN = 1'b1;
    wait_ticks(gap);
  endtask

  always @(negedge CLK) begin
    if (RXFINISHED) begin
      finish_tick = tick_count;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_finish: RXFINISHED=1 DOUT=0x%0h expected no frame", DOUT);
      end else begin
        mon_e = exp_q.pop_front();
        check("dout", DOUT, mon_e.dout);
        check("pe", PE, mon_e.pe);
        check("fe", FE, mon_e.fe);
        check("bi", BI, mon_e.bi);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge CLK);
    $display("FAIL watchdog: cycle budget exhausted, %0d frames outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_dout", DOUT, 0);
    check("reset_flags", {PE, FE, BI}, 0);
    check("reset_finished", RXFINISHED, 0);
    check("reset_busy", BUSY, 0);
    wait_ticks(4);

    send_frame(9'h0A5, 8, 0, 0, 0, 0, 0, 1, 1, 0, 8);
    check_range("latency_8n1", finish_tick - start_tick, 150, 170);
    check("busy_after_8n1", BUSY, 0);

    p = good_par(9'h1C3, 9, 1'b1, 1'b0);
    send_frame(9'h1C3, 9, 1, 1, 0, 1, p, 1, 1, 0, 8);
    send_frame(9'h1C3, 9, 1, 1, 0, 1, !p, 1, 0, 0, 8);

    SIN = 1'b0;
    wait_ticks(3);
    check("busy_in_glitch", BUSY, 1);
    wait_ticks(2);
    SIN = 1'b1;
    wait_ticks(16);
    check("busy_after_glitch", BUSY, 0);
    send_frame(9'h055, 8, 0, 0, 0, 0, 0, 1, 1, 0, 8);

    WLEN = 4'd7; PEN = 1'b0; STB = 1'b0;
    exp_q.push_back(model(9'h000, 7, 0, 0, 0, 0, 0, 0, 0));
    SIN = 1'b0;
    wait_ticks(3 * 9 * 16);
    SIN = 1'b1;
    wait_ticks(8);
    check("break_delivered", exp_q.size(), 0);
    send_frame(9'h03F, 7, 0, 0, 0, 0, 0, 1, 1, 0, 8);

    for (int f = 0; f < 24; f++) begin
      tick_per = ($urandom_range(0, 1) == 1) ? 1 : 4;
      rword = 9'($urandom);
      if ($urandom_range(0, 7) == 0) rword = '0;
      rwlen = $urandom_range(0, 15);
      rpen = 1'($urandom); reps = 1'($urandom); rsp = 1'($urandom); rstb = 1'($urandom);
      p    = good_par(rword, rwlen, reps, rsp) ^ ($urandom_range(0, 3) == 0);
      rs1  = ($urandom_range(0, 7) != 0);
      rs2  = ($urandom_range(0, 7) != 0);
      send_frame(rword, rwlen, rpen, reps, rsp, rstb, p, rs1, rs2, 1, 4 + $urandom_range(0, 8));
    end
    tick_per = 4;
    wait_ticks(4);

    send_frame(9'h05A, 8, 1, 0, 1, 0, 1, 1, 1, 0, 8);
    send_frame(9'h05A, 8, 1, 0, 1, 0, 0, 1, 1, 0, 8);

    WLEN = 4'd8; PEN = 1'b0; STB = 1'b0;
    SIN = 1'b0;
    wait_ticks(16);
    SIN = 1'b1;
    wait_ticks(16 * 3 + 8);
    check("busy_before_clear", BUSY, 1);
    RXCLEAR = 1'b1;
    @(negedge CLK);
    RXCLEAR = 1'b0;
    check("busy_after_clear", BUSY, 0);
    check("dout_kept_by_clear", DOUT, last_dout);
    check("pe_kept_by_clear", PE, 1);
    wait_ticks(20);

    SIN = 1'b0;
    wait_ticks(16 + 16 * 2 + 4);
    check("busy_before_rst", BUSY, 1);
    RST = 1'b1;
    SIN = 1'b1;
    @(negedge CLK);
    check("rst_dout", DOUT, 0);
    check("rst_flags", {PE, FE, BI}, 0);
    check("rst_finished", RXFINISHED, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b0;
    wait_ticks(40);

    check("frames_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
